add20_seq: RTL and testbench
============================

ADD20_SEQ -- requirements
Module: add20_seq

Interface
REQ-001 SHALL: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 SHALL: start  input  1  request a 20-bit addition; sampled only in IDLE.
REQ-004 SHALL: a_in  input  20  operand A, latched on accepted start.
REQ-005 SHALL: b_in  input  20  operand B, latched on accepted start.
REQ-006 SHALL: cin  input  1  carry-in to slice 0, latched on accepted start.
REQ-007 SHALL: busy  output  1  high while slices are being computed (ADD state).
REQ-008 SHALL: done  output  1  one-cycle pulse; sum_out/cout valid from this cycle on.
REQ-009 SHALL: sum_out  output  20  result of the last completed operation.
REQ-010 SHALL: cout  output  1  carry out of slice 3 of the last completed operation.
REQ-011 SHALL: sub  input  1  subtract select; present only when ADD20_SUB_EN is defined.

Function
REQ-012 SHALL: one internal 5-bit adder slice (5-bit A, 5-bit B, carry-in -> 5-bit sum, carry-out) is time-shared across four slices; bits [5k+4:5k] are processed in slice k, k = 0..3.
REQ-013 SHALL: FSM states IDLE, ADD, DONE; encoding is an implementation choice.
REQ-014 SHALL: IDLE -> ADD on the edge where start=1; a_in, b_in, cin latched at that edge; slice counter cleared to 0; internal carry register loaded with cin.
REQ-015 SHALL: in ADD, each edge computes slice k from the latched operands and carry register, writes 5 sum bits into an internal result register, stores the slice carry-out, and increments k.
REQ-016 SHALL: ADD -> DONE on the edge that computes slice 3; on that edge sum_out and cout are loaded from the internal result.
REQ-017 SHALL: DONE -> IDLE unconditionally on the next edge; done=1 only while in DONE.
REQ-018 SHALL: latency fixed: start accepted at edge E, done high in the cycle after edge E+4; busy high in cycles after edges E..E+3.
REQ-019 SHALL: start ignored in ADD and DONE; no queuing; next request accepted earliest in IDLE after DONE (6-cycle minimum request spacing).
REQ-020 SHALL: changes on a_in/b_in/cin after acceptance do not affect the in-flight result.
REQ-021 SHALL: sum_out/cout hold their value from DONE until the next DONE; never show partial results.
REQ-022 SHALL: arithmetic is unsigned modulo 2^20; {cout, sum_out} = a + b + cin exactly.

Reset
REQ-023 SHALL: rst_n=0 at any edge forces IDLE, counter 0, carry register 0, busy 0, done 0, sum_out 0, cout 0, regardless of state.
REQ-024 SHALL: reset mid-ADD aborts the operation with no done pulse; reset has priority over start in the same cycle.
REQ-025 SHALL: first start after rst_n returns high is accepted normally.

Configuration
REQ-026 SHALL: macro ADD20_SUB_EN defined -> sub port exists; when sub=1 at acceptance, latched B is ~b_in and latched carry-in is 1 (cin ignored), giving a - b mod 2^20 with cout=1 meaning no borrow; sub=0 behaves as plain add.
REQ-027 SHALL: ADD20_SUB_EN undefined -> no sub port, add-only behaviour, identical timing.

Verification
REQ-028 SHALL: a=0x00009, b=0x00009, cin=0, start 1 cycle -> busy 4 cycles, done 1 cycle later, sum_out=0x00012, cout=0.
REQ-029 SHALL: a=0xFFFFF, b=0x00001, cin=0 -> sum_out=0x00000, cout=1 (carry through all 4 slices).
REQ-030 SHALL: a=0x7FFFF, b=0x80000, cin=1 -> sum_out=0x00000, cout=1; start held high through ADD/DONE produces exactly one done per IDLE acceptance.
REQ-031 SHALL: start with a=0x12345,b=0x11111, then change a_in/b_in during ADD -> sum_out=0x23456, cout=0.
REQ-032 SHALL: rst_n low during 2nd ADD cycle -> next cycle busy=0, done=0, sum_out=0, cout=0, no done pulse; following start with a=1,b=2 -> sum_out=0x00003.
REQ-033 SHALL: with ADD20_SUB_EN, sub=1, a=0x00005, b=0x00007 -> sum_out=0xFFFFE, cout=0; a=0x00007, b=0x00005 -> sum_out=0x00002, cout=1.

Source files
------------

// File: rtl/add20_seq.sv
// add20_seq: 20-bit adder built from one 5-bit slice reused over four cycles.
// Flow: IDLE -> ADD (slices 0..3, one per clock) -> DONE (one-cycle done pulse).
// Optional build macro ADD20_SUB_EN adds a 'sub' port; sub=1 computes a - b.
module add20_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [19:0] a_in,
    input  logic [19:0] b_in,
    input  logic        cin,
`ifdef ADD20_SUB_EN
    input  logic        sub,
`endif
    output logic        busy,
    output logic        done,
    output logic [19:0] sum_out,
    output logic        cout
);

    localparam int unsigned W     = 20;
    localparam int unsigned SW    = 5;
    localparam int unsigned KW    = 2;
    localparam int unsigned RES_W = W - SW;   // slice 3 goes straight to sum_out

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [KW-1:0]      k_q;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [RES_W-1:0]   res_q;
    logic [W-1:0]       sum_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    logic [W-1:0]       b_lat_d;
    logic               c_lat_d;
    logic [SW-1:0]      a_sl;
    logic [SW-1:0]      b_sl;
    logic [SW:0]        slice_d;

    // Operand B and carry-in as they are captured on an accepted start.
    always_comb begin
        b_lat_d = b_in;
        c_lat_d = cin;
`ifdef ADD20_SUB_EN
        if (sub) begin
            b_lat_d = ~b_in;
            c_lat_d = 1'b1;
        end
`endif
    end

    // Select the 5-bit operand slices for the current slice index.
    always_comb begin
        a_sl = a_q[SW-1:0];
        b_sl = b_q[SW-1:0];
        case (k_q)
            2'd0: begin a_sl = a_q[4:0];   b_sl = b_q[4:0];   end
            2'd1: begin a_sl = a_q[9:5];   b_sl = b_q[9:5];   end
            2'd2: begin a_sl = a_q[14:10]; b_sl = b_q[14:10]; end
            2'd3: begin a_sl = a_q[19:15]; b_sl = b_q[19:15]; end
            default: begin a_sl = a_q[4:0]; b_sl = b_q[4:0]; end
        endcase
    end

    // The single shared 5-bit adder slice: {carry, sum}.
    always_comb begin
        slice_d = (SW+1)'(a_sl) + (SW+1)'(b_sl) + (SW+1)'(carry_q);
    end

    // Control FSM and datapath registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a_in;
                        b_q     <= b_lat_d;
                        carry_q <= c_lat_d;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ADD;
                    end
                end
                S_ADD: begin
                    carry_q <= slice_d[SW];
                    k_q     <= k_q + KW'(1);
                    case (k_q)
                        2'd0: res_q[4:0]   <= slice_d[SW-1:0];
                        2'd1: res_q[9:5]   <= slice_d[SW-1:0];
                        2'd2: res_q[14:10] <= slice_d[SW-1:0];
                        default: begin
                            // Last slice: publish the full result in one step.
                            sum_q   <= {slice_d[SW-1:0], res_q};
                            cout_q  <= slice_d[SW];
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    endcase
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum_out = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_add20_seq.sv
// Scoreboard bench for add20_seq: stimulus pushes expected {cout,sum}, a
// monitor pops and compares on every done pulse.
module tb_add20_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] a_in;
    logic [19:0] b_in;
    logic        cin;
    logic        sub;
    logic        busy;
    logic        done;
    logic [19:0] sum_out;
    logic        cout;

    int tests;
    int fails;
    int done_cnt;
    logic [20:0] exp_q[$];

    add20_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
`ifdef ADD20_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            tests = tests + 1;
            if (exp_q.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_done: got sum=%h cout=%b, required no done pulse",
                         sum_out, cout);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                if ({cout, sum_out} !== e) begin
                    fails = fails + 1;
                    $display("FAIL result: got cout=%b sum=%h, required cout=%b sum=%h",
                             cout, sum_out, e[20], e[19:0]);
                end
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check20(input string name, input logic [19:0] act, input logic [19:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // One operation with full timing checks; inputs are scrambled after acceptance.
    task automatic run_op(input logic [19:0] a, input logic [19:0] b, input logic c,
                          input logic s, input logic [19:0] exp_sum, input logic exp_cout,
                          input logic hold_start);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        exp_q.push_back({exp_cout, exp_sum});
        @(negedge clk);                     // after accept edge E
        if (!hold_start) start = 1'b0;
        a_in = 20'h5A5A5;
        b_in = 20'hA5A5A;
        cin  = ~c;
        sub  = ~s;
        check1("busy_c1", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin   // after E+1..E+3
            @(negedge clk);
            check1("busy_mid", busy, 1'b1);
            check1("done_early", done, 1'b0);
        end
        @(negedge clk);                     // after E+4
        check1("busy_at_done", busy, 1'b0);
        check1("done_pulse", done, 1'b1);
        @(negedge clk);                     // after E+5: back in IDLE
        check1("done_one_cycle", done, 1'b0);
        check1("busy_idle", busy, 1'b0);
        check20("sum_hold", sum_out, exp_sum);
        check1("cout_hold", cout, exp_cout);
        start = 1'b0;                       // released before edge E+6
        sub   = 1'b0;
    endtask

    initial begin
        int d0;
        tests = 0;
        fails = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        sub   = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check20("rst_sum", sum_out, 20'h00000);
        check1("rst_cout", cout, 1'b0);
        rst_n = 1'b1;

        run_op(20'h00009, 20'h00009, 1'b0, 1'b0, 20'h00012, 1'b0, 1'b0);
        run_op(20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
        run_op(20'h0001F, 20'h00001, 1'b0, 1'b0, 20'h00020, 1'b0, 1'b0);
        run_op(20'hABCDE, 20'h54321, 1'b0, 1'b0, 20'hFFFFF, 1'b0, 1'b0);
        run_op(20'h00000, 20'h00000, 1'b1, 1'b0, 20'h00001, 1'b0, 1'b0);

        // Start held high through ADD and DONE: exactly one done.
        d0 = done_cnt;
        run_op(20'h7FFFF, 20'h80000, 1'b1, 1'b0, 20'h00000, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        tests = tests + 1;
        if (done_cnt - d0 != 1) begin
            fails = fails + 1;
            $display("FAIL held_start_dones: got %0d, required 1", done_cnt - d0);
        end

        run_op(20'h12345, 20'h11111, 1'b0, 1'b0, 20'h23456, 1'b0, 1'b0);

        // Reset during the second ADD cycle aborts with no done.
        @(negedge clk);
        a_in  = 20'h0F0F0;
        b_in  = 20'h00F0F;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);                     // after accept edge E
        start = 1'b0;
        check1("abort_busy_pre", busy, 1'b1);
        @(negedge clk);                     // second ADD cycle
        rst_n = 1'b0;
        start = 1'b1;                       // reset must win over start
        @(negedge clk);
        check1("abort_busy", busy, 1'b0);
        check1("abort_done", done, 1'b0);
        check20("abort_sum", sum_out, 20'h00000);
        check1("abort_cout", cout, 1'b0);
        rst_n = 1'b1;
        start = 1'b0;
        d0 = done_cnt;
        repeat (8) @(negedge clk);
        tests = tests + 1;
        if (done_cnt != d0) begin
            fails = fails + 1;
            $display("FAIL abort_no_done: got %0d pulses, required 0", done_cnt - d0);
        end
        run_op(20'h00001, 20'h00002, 1'b0, 1'b0, 20'h00003, 1'b0, 1'b0);

`ifdef ADD20_SUB_EN
        run_op(20'h00005, 20'h00007, 1'b0, 1'b1, 20'hFFFFE, 1'b0, 1'b0);
        run_op(20'h00007, 20'h00005, 1'b0, 1'b1, 20'h00002, 1'b1, 1'b0);
        run_op(20'h00007, 20'h00005, 1'b1, 1'b0, 20'h0000D, 1'b0, 1'b0);
`endif

        repeat (4) @(negedge clk);
        tests = tests + 1;
        if (exp_q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL missing_done: got %0d outstanding, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
